// File: rtl/intc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// intc_ctrl_pkg
// Shared constants for the interrupt controller and for the bridge that
// decodes its window:
//   - word offsets of the four slave registers (PrAddr[3:2])
//   - bit positions of the fields inside CTRL
//   - controller state encodings
// -----------------------------------------------------------------------------
package intc_ctrl_pkg;

   // Register word offsets
   localparam logic [1:0] INTC_CTRL = 2'd0;
   localparam logic [1:0] INTC_MASK = 2'd1;
   localparam logic [1:0] INTC_PEND = 2'd2;
   localparam logic [1:0] INTC_ACK  = 2'd3;

   // CTRL field positions: GEN at bit 0, EDGE mode at [13:8], HOLDOFF at [23:16]
   localparam int CTRL_GEN_BIT  = 0;
   localparam int CTRL_EDGE_LSB = 8;
   localparam int CTRL_HOLD_LSB = 16;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } intc_state_t;

endpackage

// File: rtl/intc_prio.sv
// -----------------------------------------------------------------------------
// intc_prio
// Combinational priority encoder. Bit 0 has the highest priority.
// o_code = 1 + index of the lowest set bit of i_req, or 0 when none is set.
// Ports:
//   i_req  [N-1:0]  request vector
//   o_code [2:0]    encoded priority code
// -----------------------------------------------------------------------------
module intc_prio #(
   parameter int N = 6
) (
   input  logic [N-1:0] i_req,
   output logic [2:0]   o_code
);

   // Scan from the lowest priority upward so the highest-priority hit wins.
   always_comb begin
      o_code = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_code = 3'(i + 1);
         end
      end
   end

endmodule

// File: rtl/intc_ctrl.sv
// -----------------------------------------------------------------------------
// intc_ctrl
// Interrupt controller between six peripheral IRQ lines and CPU HWInt[7:2].
// Memory-mapped slave on the Pr bus: CTRL / MASK / PEND / ACK at offsets 0..3.
// Latches and masks requests, drives a registered request vector, and after
// a CPU acknowledge holds the vector low for a programmable number of cycles.
//
// Optional build macro: INTC_SYNC_EN -- when defined, every i_irq bit goes
// through a 2-flop synchronizer before edge detection (adds 2 cycles).
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   i_irq    raw request lines, bit 0 highest priority
//   i_sel    slave select
//   i_we     write strobe (qualified by i_sel)
//   i_addr   word offset
//   i_wdata  write data
//   o_rdata  read data, combinational, 0 when not selected
//   o_hwint  registered request vector to the CPU
//   o_busy   high while the hold-off window is running
// -----------------------------------------------------------------------------
module intc_ctrl
   import intc_ctrl_pkg::*;
#(
   parameter int N_SRC     = 6,
   parameter int HOLDOFF_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_SRC-1:0]     i_irq,
   input  logic                 i_sel,
   input  logic                 i_we,
   input  logic [1:0]           i_addr,
   input  logic [31:0]          i_wdata,
   output logic [31:0]          o_rdata,
   output logic [N_SRC-1:0]     o_hwint,
   output logic                 o_busy
);

   logic                 r_gen;
   logic [N_SRC-1:0]     r_edge;
   logic [HOLDOFF_W-1:0] r_holdoff;
   logic [N_SRC-1:0]     r_mask;
   logic [N_SRC-1:0]     r_pend;
   logic [N_SRC-1:0]     r_prev;
   logic [HOLDOFF_W-1:0] r_cnt;
   intc_state_t          r_state;
   logic [N_SRC-1:0]     r_hwint;
   logic                 r_busy;

   logic [N_SRC-1:0]     w_s_irq;
   logic [N_SRC-1:0]     w_w1c;
   logic [N_SRC-1:0]     w_pend_next;
   logic [N_SRC-1:0]     w_active;
   logic [2:0]           w_code;
   logic                 w_wr;
   logic                 w_wr_ctrl;
   logic                 w_wr_mask;
   logic                 w_wr_pend;
   logic                 w_wr_ack;
   logic                 w_unused_wdata;

   // Only some write-data bits map to register fields.
   assign w_unused_wdata = ^i_wdata;

   assign w_wr      = i_sel & i_we;
   assign w_wr_ctrl = w_wr && (i_addr == INTC_CTRL);
   assign w_wr_mask = w_wr && (i_addr == INTC_MASK);
   assign w_wr_pend = w_wr && (i_addr == INTC_PEND);
   assign w_wr_ack  = w_wr && (i_addr == INTC_ACK);

`ifdef INTC_SYNC_EN
   logic [N_SRC-1:0] r_sync1;
   logic [N_SRC-1:0] r_sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_irq;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s_irq = r_sync2;
`else
   assign w_s_irq = i_irq;
`endif

   assign w_w1c = w_wr_pend ? i_wdata[N_SRC-1:0] : '0;

   // Level bits simply follow the sampled line (so W1C cannot touch them);
   // edge bits are sticky and a new edge beats a same-cycle clear.
   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
      assign w_pend_next[gi] = r_edge[gi]
         ? ((w_s_irq[gi] & ~r_prev[gi]) | (r_pend[gi] & ~w_w1c[gi]))
         : w_s_irq[gi];
   end

   assign w_active = r_pend & r_mask & {N_SRC{r_gen}};

   intc_prio #(.N(N_SRC)) u_prio (
      .i_req  (w_active),
      .o_code (w_code)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gen     <= 1'b0;
         r_edge    <= '0;
         r_holdoff <= '0;
         r_mask    <= '0;
         r_pend    <= '0;
         r_prev    <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_gen     <= i_wdata[CTRL_GEN_BIT];
            r_edge    <= i_wdata[CTRL_EDGE_LSB +: N_SRC];
            r_holdoff <= i_wdata[CTRL_HOLD_LSB +: HOLDOFF_W];
         end
         if (w_wr_mask) begin
            r_mask <= i_wdata[N_SRC-1:0];
         end
         r_prev <= w_s_irq;
         r_pend <= w_pend_next;
      end
   end

   // Acknowledge / hold-off state machine with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_hwint <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_wr_ack && (r_holdoff != '0)) begin
                  r_cnt   <= r_holdoff;
                  r_hwint <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_HOLD;
               end else begin
                  r_hwint <= w_active;
               end
            end
            S_HOLD: begin
               r_hwint <= '0;
               if (w_wr_ack) begin
                  r_cnt <= r_holdoff;
               end else if (r_cnt <= HOLDOFF_W'(1)) begin
                  // <= also catches a reload with HOLDOFF = 0
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - HOLDOFF_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o_rdata = '0;
      if (i_sel) begin
         case (i_addr)
            INTC_CTRL: begin
               o_rdata[CTRL_GEN_BIT]                  = r_gen;
               o_rdata[CTRL_EDGE_LSB +: N_SRC]        = r_edge;
               o_rdata[CTRL_HOLD_LSB +: HOLDOFF_W]    = r_holdoff;
            end
            INTC_MASK: o_rdata[N_SRC-1:0] = r_mask;
            INTC_PEND: o_rdata[N_SRC-1:0] = r_pend;
            INTC_ACK:  o_rdata[2:0]       = w_code;
            default:   o_rdata = '0;
         endcase
      end
   end

   assign o_hwint = r_hwint;
   assign o_busy  = r_busy;

endmodule

// File: tb/tb_intc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intc_ctrl
// Directed bench for intc_ctrl. Expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
// Inputs change and outputs are sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_intc_ctrl;

`ifdef INTC_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        reset;
   logic [5:0]  i_irq;
   logic        i_sel;
   logic        i_we;
   logic [1:0]  i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic [5:0]  o_hwint;
   logic        o_busy;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   intc_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .i_irq   (i_irq),
      .i_sel   (i_sel),
      .i_we    (i_we),
      .i_addr  (i_addr),
      .i_wdata (i_wdata),
      .o_rdata (o_rdata),
      .o_hwint (o_hwint),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push_exp(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic chk(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed=0x%0h expected=<none>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", t, obs, e);
         end
         $display("check %-14s observed=0x%0h expected=0x%0h", t, obs, e);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
      @(negedge clk);
      i_sel = 1'b0; i_we = 1'b0; i_wdata = '0;
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
      @(negedge clk);
      i_sel = 1'b1; i_we = 1'b0; i_addr = a;
      push_exp(tag, e);
      #1;
      chk(o_rdata);
      i_sel = 1'b0;
   endtask

   task automatic chk_hw(input string tag, input logic [5:0] e);
      push_exp(tag, {26'b0, e});
      chk({26'b0, o_hwint});
   endtask

   // Runs an ACK at the current falling edge and follows {busy,hwint} for
   // n cycles; a second ACK is issued at cycle reack (0 = none).
   task automatic ack_window(input int n, input int reack, input string tag);
      @(negedge clk);
      i_sel = 1'b1; i_we = 1'b1; i_addr = 2'd3; i_wdata = 32'h0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         #1;
         chk({25'b0, o_busy, o_hwint});
         i_sel = (c == reack);
         i_we  = (c == reack);
      end
      $display("ack_window %s done", tag);
   endtask

   initial begin
      reset = 1'b1; i_irq = '0; i_sel = 1'b0; i_we = 1'b0;
      i_addr = '0; i_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;

      // Reset state
      chk_hw("rst_hwint", 6'h00);
      push_exp("rst_busy", 32'h0); chk({31'b0, o_busy});
      rd(2'd0, 32'h0, "rst_ctrl");
      rd(2'd1, 32'h0, "rst_mask");
      rd(2'd2, 32'h0, "rst_pend");
      rd(2'd3, 32'h0, "rst_ack");

      // Single edge pulse on source 2
      wr(2'd0, 32'h0000_3F01);
      wr(2'd1, 32'h0000_003F);
      rd(2'd0, 32'h0000_3F01, "ctrl_rb");
      @(negedge clk); i_irq = 6'h04;
      @(negedge clk); i_irq = 6'h00;
      push_exp("edge2_early", 32'h00);
      push_exp("edge2_lat", 32'h04);
      repeat (LAT - 2) @(negedge clk);
      #1; chk({26'b0, o_hwint});
      step(); chk({26'b0, o_hwint});
      rd(2'd3, 32'd3, "ack_code3");
      rd(2'd2, 32'h04, "pend_src2");
      wr(2'd2, 32'h04);
      step(); chk_hw("w1c_clear", 6'h00);

      // Sources 0 and 5 rise together
      @(negedge clk); i_irq = 6'h21;
      repeat (LAT) step();
      chk_hw("dual_hw", 6'h21);
      rd(2'd2, 32'h21, "dual_pend");
      rd(2'd3, 32'd1, "dual_ack1");
      wr(2'd1, 32'h0000_003E);
      rd(2'd3, 32'd6, "mask_ack6");
      chk_hw("mask_hw", 6'h20);
      // Clearing GEN drops the output but keeps pending
      wr(2'd0, 32'h0000_3F00);
      step(); chk_hw("gen_off_hw", 6'h00);
      rd(2'd2, 32'h21, "gen_off_pend");
      // Writes without select are ignored
      @(negedge clk); i_sel = 1'b0; i_we = 1'b1; i_addr = 2'd1; i_wdata = 32'h0;
      @(negedge clk); i_we = 1'b0;
      rd(2'd1, 32'h3E, "nosel_mask");
      i_irq = 6'h00;
      wr(2'd2, 32'h3F);
      wr(2'd0, 32'h0000_3D01);
      wr(2'd1, 32'h0000_003F);
      rd(2'd2, 32'h00, "pend_clean");

      // Level mode on source 1
      @(negedge clk); i_irq = 6'h02;
      repeat (LAT) step();
      chk_hw("lvl_hw", 6'h02);
      wr(2'd2, 32'h02);
      step(); step();
      chk_hw("lvl_w1c_hw", 6'h02);
      rd(2'd2, 32'h02, "lvl_w1c_pend");
      @(negedge clk); i_irq = 6'h00;
      repeat (LAT - 1) step();
      chk_hw("lvl_drop_early", 6'h02);
      step(); chk_hw("lvl_drop", 6'h00);

      // Hold-off of 4 cycles on source 3
      wr(2'd0, 32'h0004_3F01);
      @(negedge clk); i_irq = 6'h08;
      @(negedge clk); i_irq = 6'h00;
      repeat (LAT - 1) step();
      chk_hw("hold_pre_hw", 6'h08);
      for (int c = 1; c <= 4; c++) push_exp("hold4_busy", 32'h40);
      push_exp("hold4_exit", 32'h00);
      push_exp("hold4_hw", 32'h08);
      ack_window(6, 0, "hold4");

      // Second ACK at cycle 2 stretches busy to 6 cycles
      for (int c = 1; c <= 6; c++) push_exp("hold6_busy", 32'h40);
      push_exp("hold6_exit", 32'h00);
      push_exp("hold6_hw", 32'h08);
      ack_window(8, 2, "hold6");

      // Asynchronous reset in the middle of hold-off
      @(negedge clk);
      i_sel = 1'b1; i_we = 1'b1; i_addr = 2'd3;
      @(negedge clk);
      i_sel = 1'b0; i_we = 1'b0;
      #1;
      push_exp("mid_hold_busy", 32'h40); chk({25'b0, o_busy, o_hwint});
      #1 reset = 1'b1;
      #1;
      push_exp("async_rst_out", 32'h00); chk({25'b0, o_busy, o_hwint});
      @(negedge clk); reset = 1'b0;
      rd(2'd0, 32'h0, "post_rst_ctrl");
      rd(2'd1, 32'h0, "post_rst_mask");
      rd(2'd2, 32'h0, "post_rst_pend");
      rd(2'd3, 32'h0, "post_rst_ack");
      chk_hw("post_rst_hw", 6'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/intc_ctrl.md
Name: intc_ctrl

Overview:
- Interrupt controller between six peripheral IRQ lines and the CPU HWInt[7:2] inputs.
- Sits on the bridge as a memory-mapped slave on the Pr bus, at word offsets 0..3 of its window.
- Latches and masks requests, resolves priority, and drives a registered interrupt vector to CP0.
- After CPU acknowledge, enforces a programmable hold-off so a re-asserting source cannot re-interrupt immediately.

Parameters:
- N_SRC, 6, number of interrupt sources; fixed to match HWInt[7:2].
- HOLDOFF_W, 8, width of the hold-off counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_irq  input  6  raw device request lines; bit 0 is highest priority
- i_sel  input  1  bridge selects this slave this cycle
- i_we  input  1  write strobe, qualified by i_sel
- i_addr  input  2  word offset (PrAddr[3:2])
- i_wdata  input  32  write data (PrWD)
- o_rdata  output  32  read data, combinational from registers
- o_hwint  output  6  registered request vector to CPU HWInt[7:2]
- o_busy  output  1  high while in HOLDOFF state

Behaviour:
- Register map, by word offset:
  - 0 CTRL: bit0 GEN (global enable); bits[13:8] EDGE mode per source, 1 = edge, 0 = level; bits[23:16] HOLDOFF count; other bits read 0.
  - 1 MASK: bits[5:0] per-source enable.
  - 2 PEND: read returns pending[5:0]; a write clears pending bits where wdata = 1 (W1C); level-mode bits ignore W1C.
  - 3 ACK: read returns {26'b0, code}, where code = 1 + index of the highest-priority active source, or 0 if none; any write is the CPU acknowledge.
- Reset:
  - CTRL = 0, MASK = 0, pending = 0, prev-sample = 0, counter = 0, state = IDLE.
  - o_hwint = 0, o_busy = 0.
- Sampling:
  - s_irq = i_irq, or the synchronized copy when the optional feature is enabled.
  - prev register holds last cycle's s_irq.
- Pending update, per bit, each cycle:
  - Level mode: pending = s_irq.
  - Edge mode: set on s_irq & ~prev. Cleared by W1C at offset 2. Set and clear in the same cycle: set wins.
- active = pending & MASK & {6{GEN}}.
- State machine:
  - IDLE: o_hwint <= active. Leave IDLE on an ACK write.
    - HOLDOFF = 0: stay in IDLE; ACK has no effect beyond the write.
    - HOLDOFF != 0: counter <= HOLDOFF, o_hwint <= 0, go to HOLDOFF.
  - HOLDOFF: o_hwint held 0; pending continues to accumulate; counter decrements each cycle. When counter == 1, go to IDLE, so o_hwint shows active on the next edge.
  - ACK write while in HOLDOFF reloads the counter.
- Latency: source edge to o_hwint is 2 cycles without sync (prev/pending, then o_hwint); 4 cycles with sync.
- Register writes take effect on the next edge.
  - A MASK write lowers o_hwint one cycle after it is applied.
  - Clearing GEN forces o_hwint = 0 on the following cycle; it does not affect pending.
- Writes with i_sel = 0 are ignored.
- o_rdata is valid whenever i_sel = 1; it is 0 otherwise.
- Reset asserted mid-HOLDOFF returns the block to IDLE with all state cleared immediately (async).

Optional Feature:
- Macro INTC_SYNC_EN.
- Defined: each i_irq bit passes through a 2-flop synchronizer, reset to 0, before edge detection; adds 2 cycles of latency.
- Undefined: i_irq is used directly and is assumed synchronous to clk.

Decomposition:
- Shared package/header (included alongside macrodefine.v) holds:
  - offset constants INTC_CTRL = 2'd0, INTC_MASK = 2'd1, INTC_PEND = 2'd2, INTC_ACK = 2'd3;
  - CTRL field bit positions;
  - state encodings S_IDLE, S_HOLD.
- One natural sub-module, intc_prio: a combinational 6-to-3 priority encoder producing the ACK code, also reusable by the bridge.

Test Plan:
- Reset, then read all four offsets -> all 0; o_hwint = 0, o_busy = 0.
- Write CTRL = 0x0000_3F01 and MASK = 0x3F, pulse i_irq[2] for 1 cycle -> o_hwint = 6'b000100 two cycles later (four with INTC_SYNC_EN); ACK reads 3; W1C PEND = 0x4 -> o_hwint = 0 the cycle after.
- Edge mode with i_irq[0] and i_irq[5] rising together -> PEND = 0x21, ACK code = 1; mask bit 0 off -> ACK code = 6, o_hwint = 6'b100000.
- Level mode on source 1: hold i_irq[1] high -> o_hwint[1] stays 1; W1C has no effect; drop i_irq[1] -> o_hwint[1] = 0 after 2 cycles.
- HOLDOFF = 4, source 3 pending, write ACK -> o_busy = 1 and o_hwint = 0 for 4 cycles, then o_hwint = 6'b001000; an ACK at cycle 2 extends the window to 6 cycles total.
- Assert reset in the middle of HOLDOFF -> o_busy and o_hwint drop to 0 within the same cycle; registers read 0.
